wbu_commit: RTL and testbench
=============================

Name: wbu_commit

Overview:
- In-order writeback/commit unit. It is the writer side of the integer register file.
- Accepts execute results via a valid/ready channel and buffers them in an in-order queue. Load entries are completed by out-of-band LSU responses.
- Retires one entry per cycle as a registered write port (rf_wen/rf_waddr/rf_wdata) driving the GPR write port.
- Reports RAW hazards on rs1/rs2 to decode.

Parameters:
- DEPTH, 4, queue entries; power of 2, minimum 2.
- XLEN, 32, data width.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  execute result valid
- in_ready  out  1  queue can accept
- in_wen  in  1  instruction writes rd
- in_rd  in  5  destination register
- in_is_load  in  1  data comes later from LSU; in_data ignored
- in_data  in  XLEN  final rd value (ALU/PC/imm/CSR, already muxed)
- mem_rsp_valid  in  1  LSU load data valid; always accepted, no backpressure
- mem_rsp_data  in  XLEN  aligned, extended load data
- rf_wen  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data
- hz_rs1_addr  in  5  decode rs1
- hz_rs2_addr  in  5  decode rs2
- hz_rs1  out  1  rs1 has a pending write
- hz_rs2  out  1  rs2 has a pending write
- retired_cnt  out  CNT_W  entries retired since reset; wraps
- err_orphan_rsp  out  1  sticky: LSU response with no pending load

Behaviour:
- Reset (async, rst=1): queue empty, all pointers 0, rf_wen=0, rf_waddr=0, rf_wdata=0, retired_cnt=0, err_orphan_rsp=0. in_ready=1 once rst deasserts. A reset mid-operation discards all entries and pending loads.
- Queue entry fields: wen, rd, data, dv (data valid).
- Enqueue: on in_valid && in_ready, write an entry at tail.
  - dv = !in_is_load; data = in_data for non-loads.
  - Entries with in_wen=0 are queued anyway to preserve order and count.
- in_ready = !full. It depends only on occupancy: no pass-through when full, even if a retire happens the same cycle.
- Load completion:
  - A load pointer tracks the oldest stored entry with is_load && !dv.
  - On mem_rsp_valid, that entry gets data=mem_rsp_data, dv=1, and the load pointer advances.
  - If no such entry exists (including a load being enqueued the same cycle), the response is dropped and err_orphan_rsp is set; it is cleared only by reset.
- Retire: when the head is valid and dv=1, at the clock edge:
  - pop the head;
  - rf_wen <= wen && rd!=0, rf_waddr <= rd, rf_wdata <= data;
  - retired_cnt increments.
- When there is no retire, rf_wen <= 0; rf_waddr and rf_wdata hold their values.
- Latency, non-load into an empty queue:
  - accepted at edge t, retires at edge t+1;
  - rf_wen is high in the cycle after edge t+1 and is consumed by the GPR at edge t+2.
- A load whose response arrives in the cycle after its enqueue edge retires at the following edge. The response-to-head path is not combinational; dv is registered.
- Simultaneous enqueue, retire and mem response in one cycle are all legal. Occupancy changes by enq - deq. Pointers wrap modulo DEPTH.
- Hazard (combinational): hz_rsN = (rsN!=0) && (any valid queue entry with wen && rd==rsN, or rf_wen && rf_waddr==rsN). The rf output stage counts because the GPR has not yet been written.
- Writes to x0 never assert rf_wen and never raise a hazard.

Decomposition:
- Shared package wbu_pkg:
  - XLEN/REG_AW constants;
  - wbu_entry_t typedef {wen, rd, is_load, dv, data};
  - default DEPTH.
- One sub-module wbu_queue: circular buffer storage with head/tail/load pointers, full/empty, and load fill.
- The top level holds the retire register stage, the hazard compare, and the counters.

Test Plan:
- Reset, then three non-loads (rd=5/6/7, data=0x11/0x22/0x33) on back-to-back cycles -> rf writes x5=0x11, x6=0x22, x7=0x33 on consecutive cycles starting 2 edges after the first accept; retired_cnt=3.
- Load rd=8, then ALU rd=9 data=0x99; delay mem_rsp_valid 5 cycles with data 0xDEADBEEF -> x9 is not written until x8=0xDEADBEEF is written; order is x8 then x9; hz_rs1 for rs1=9 stays high throughout.
- Fill 4 loads with no response -> in_ready=0 and in_valid is held. Then respond 0xA,0xB,0xC,0xD on 4 consecutive cycles -> the 4 writes are in order and in_ready returns to 1.
- mem_rsp_valid with an empty queue -> err_orphan_rsp=1 stays high, no rf write; cleared only by rst.
- Entry with rd=0 and data=0x55 -> rf_wen stays 0, retired_cnt increments, hz_rs1 with rs1=0 stays 0.
- Assert rst while 2 loads are pending -> all outputs go to 0 immediately (async); a later response sets err_orphan_rsp.

Source files
------------

// File: rtl/wbu_pkg.sv
// Shared types and constants for the writeback/commit unit.
package wbu_pkg;

  localparam int XLEN          = 32;
  localparam int REG_AW        = 5;
  localparam int DEPTH_DEFAULT = 4;

  // One in-order queue slot. dv marks that data holds the final rd value.
  typedef struct packed {
    logic              wen;
    logic [REG_AW-1:0] rd;
    logic              is_load;
    logic              dv;
    logic [XLEN-1:0]   data;
  } wbu_entry_t;

endpackage

// File: rtl/wbu_queue.sv
// Circular in-order result buffer with head/tail pointers and in-order load fill.
module wbu_queue
  import wbu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enq_i,
  input  wbu_entry_t                    enq_entry_i,
  input  logic                          deq_i,
  input  logic                          rsp_valid_i,
  input  logic [XLEN-1:0]               rsp_data_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          head_wen_o,
  output logic [REG_AW-1:0]             head_rd_o,
  output logic                          head_dv_o,
  output logic [XLEN-1:0]               head_data_o,
  output logic [DEPTH-1:0]              pend_wen_o,
  output logic [DEPTH-1:0][REG_AW-1:0]  pend_rd_o,
  output logic                          orphan_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [AW-1:0]               head_q, head_d;
  logic [AW-1:0]               tail_q, tail_d;
  logic [CW-1:0]               count_q, count_d;
  wbu_entry_t [DEPTH-1:0]      mem_q, mem_d;

  logic                        ld_found;
  logic [AW-1:0]               ld_ptr;
  logic                        fill;

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign head_wen_o  = mem_q[head_q].wen;
  assign head_rd_o   = mem_q[head_q].rd;
  assign head_dv_o   = mem_q[head_q].dv;
  assign head_data_o = mem_q[head_q].data;
  assign fill        = rsp_valid_i && ld_found;
  assign orphan_o    = rsp_valid_i && !ld_found;

  // Load pointer: oldest stored entry still waiting for LSU data, searched from head.
  always_comb begin
    logic [AW-1:0] idx;
    ld_found = 1'b0;
    ld_ptr   = head_q;
    idx      = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if (!ld_found && (CW'(i) < count_q) && mem_q[idx].is_load && !mem_q[idx].dv) begin
        ld_found = 1'b1;
        ld_ptr   = idx;
      end
    end
  end

  // Per-slot view of pending register writes for the hazard compare.
  always_comb begin
    logic [AW-1:0] off;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off           = AW'(i) - head_q;
      pend_wen_o[i] = (CW'(off) < count_q) && mem_q[i].wen;
      pend_rd_o[i]  = mem_q[i].rd;
    end
  end

  // Next pointer/occupancy and slot contents; fill and enqueue never target the same slot.
  always_comb begin
    head_d  = head_q + AW'(deq_i);
    tail_d  = tail_q + AW'(enq_i);
    count_d = count_q + CW'(enq_i) - CW'(deq_i);
    mem_d   = mem_q;
    if (fill) begin
      mem_d[ld_ptr].data = rsp_data_i;
      mem_d[ld_ptr].dv   = 1'b1;
    end
    if (enq_i) begin
      mem_d[tail_q] = enq_entry_i;
    end
  end

  // Control state: pointers and occupancy, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Slot storage; contents are only meaningful inside the occupied window.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/wbu_commit.sv
// In-order writeback/commit: queue results, retire one per cycle to the GPR write port.
module wbu_commit
  import wbu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int XLEN  = wbu_pkg::XLEN,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic [4:0]        in_rd,
  input  logic              in_is_load,
  input  logic [XLEN-1:0]   in_data,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  output logic              rf_wen,
  output logic [4:0]        rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  input  logic [4:0]        hz_rs1_addr,
  input  logic [4:0]        hz_rs2_addr,
  output logic              hz_rs1,
  output logic              hz_rs2,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic              err_orphan_rsp
);

  // Queue storage width comes from the package; a mismatched override cannot work.
  if (XLEN != wbu_pkg::XLEN || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("wbu_commit: XLEN must equal wbu_pkg::XLEN and DEPTH must be a power of 2 >= 2");
  end

  logic                          q_full, q_empty, orphan;
  logic                          head_wen, head_dv;
  logic [REG_AW-1:0]             head_rd;
  logic [XLEN-1:0]               head_data;
  logic [DEPTH-1:0]              pend_wen;
  logic [DEPTH-1:0][REG_AW-1:0]  pend_rd;
  logic                          enq, retire;
  wbu_entry_t                    enq_entry;

  logic                          rf_wen_q, rf_wen_d;
  logic [REG_AW-1:0]             rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]               rf_wdata_q, rf_wdata_d;
  logic [CNT_W-1:0]              retired_cnt_q, retired_cnt_d;
  logic                          err_q, err_d;

  // Backpressure depends on occupancy only, never on a same-cycle retire.
  assign in_ready = !q_full;
  assign enq      = in_valid && !q_full;
  assign retire   = !q_empty && head_dv;

  // Build the entry; loads start without data and are completed by the LSU.
  always_comb begin
    enq_entry.wen     = in_wen;
    enq_entry.rd      = in_rd;
    enq_entry.is_load = in_is_load;
    enq_entry.dv      = !in_is_load;
    enq_entry.data    = in_is_load ? '0 : in_data;
  end

  wbu_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .enq_i       (enq),
    .enq_entry_i (enq_entry),
    .deq_i       (retire),
    .rsp_valid_i (mem_rsp_valid),
    .rsp_data_i  (mem_rsp_data),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .head_wen_o  (head_wen),
    .head_rd_o   (head_rd),
    .head_dv_o   (head_dv),
    .head_data_o (head_data),
    .pend_wen_o  (pend_wen),
    .pend_rd_o   (pend_rd),
    .orphan_o    (orphan)
  );

  // Retire stage next state: x0 writes retire and count but never enable the GPR.
  always_comb begin
    rf_wen_d      = 1'b0;
    rf_waddr_d    = rf_waddr_q;
    rf_wdata_d    = rf_wdata_q;
    retired_cnt_d = retired_cnt_q;
    err_d         = err_q | orphan;
    if (retire) begin
      rf_wen_d      = head_wen && (head_rd != '0);
      rf_waddr_d    = head_rd;
      rf_wdata_d    = head_data;
      retired_cnt_d = retired_cnt_q + CNT_W'(1);
    end
  end

  // Registered GPR write port, retire counter and sticky orphan flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen_q      <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      retired_cnt_q <= '0;
      err_q         <= 1'b0;
    end else begin
      rf_wen_q      <= rf_wen_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      retired_cnt_q <= retired_cnt_d;
      err_q         <= err_d;
    end
  end

  assign rf_wen         = rf_wen_q;
  assign rf_waddr       = rf_waddr_q;
  assign rf_wdata       = rf_wdata_q;
  assign retired_cnt    = retired_cnt_q;
  assign err_orphan_rsp = err_q;

  // RAW hazard: any queued writer or the not-yet-consumed output stage; x0 never hazards.
  always_comb begin
    hz_rs1 = rf_wen_q && (rf_waddr_q == hz_rs1_addr);
    hz_rs2 = rf_wen_q && (rf_waddr_q == hz_rs2_addr);
    for (int i = 0; i < DEPTH; i++) begin
      if (pend_wen[i] && (pend_rd[i] == hz_rs1_addr)) hz_rs1 = 1'b1;
      if (pend_wen[i] && (pend_rd[i] == hz_rs2_addr)) hz_rs2 = 1'b1;
    end
    if (hz_rs1_addr == '0) hz_rs1 = 1'b0;
    if (hz_rs2_addr == '0) hz_rs2 = 1'b0;
  end

endmodule

// File: tb/tb_wbu_commit.sv
// Scoreboard bench for wbu_commit: expected GPR writes queued at accept, checked by a monitor.
module tb_wbu_commit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_wen = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        in_is_load = 1'b0;
  logic [31:0] in_data = '0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  hz_rs1_addr = '0;
  logic [4:0]  hz_rs2_addr = '0;
  logic        hz_rs1, hz_rs2;
  logic [31:0] retired_cnt;
  logic        err_orphan_rsp;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  wbu_commit #(.DEPTH(4), .XLEN(32), .CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_wen         (in_wen),
    .in_rd          (in_rd),
    .in_is_load     (in_is_load),
    .in_data        (in_data),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .rf_wen         (rf_wen),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .hz_rs1_addr    (hz_rs1_addr),
    .hz_rs2_addr    (hz_rs2_addr),
    .hz_rs1         (hz_rs1),
    .hz_rs2         (hz_rs2),
    .retired_cnt    (retired_cnt),
    .err_orphan_rsp (err_orphan_rsp)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every GPR write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && rf_wen) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rf_write_unexpected: got x%0d=0x%0h, required no write", rf_waddr, rf_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
          errors++;
          $display("FAIL rf_write: got x%0d=0x%0h, required x%0d=0x%0h",
                   rf_waddr, rf_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one result; waits (bounded) for in_ready, pushes the expected write on accept.
  task automatic send(input logic wen, input logic [4:0] rd, input logic ld,
                      input logic [31:0] data, input logic [31:0] expd, input bit push);
    int n = 0;
    in_valid   = 1'b1;
    in_wen     = wen;
    in_rd      = rd;
    in_is_load = ld;
    in_data    = data;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 100 cycles, required 1 (rd=%0d)", rd);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (push && wen && rd != 5'd0) sb.push_back('{addr: rd, data: expd});
    end
  endtask

  task automatic rsp(input logic [31:0] d);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d;
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] cnt0;

    // Reset state
    cyc(2);
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_retired_cnt", retired_cnt, 0);
    chk("rst_err_orphan", err_orphan_rsp, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Three back-to-back non-loads; first write visible after the second edge.
    send(1, 5'd5, 0, 32'h11, 32'h11, 1);
    send(1, 5'd6, 0, 32'h22, 32'h22, 1);
    chk("lat_first_wen", rf_wen, 1);
    chk("lat_first_addr", rf_waddr, 5);
    chk("lat_first_data", rf_wdata, 32'h11);
    send(1, 5'd7, 0, 32'h33, 32'h33, 1);
    chk("lat_second_addr", rf_waddr, 6);
    cyc(3);
    chk("retired_cnt_3", retired_cnt, 3);

    // Load x8 then ALU x9, response delayed: x9 must wait and stay hazarded.
    hz_rs1_addr = 5'd9;
    hz_rs2_addr = 5'd8;
    send(1, 5'd8, 1, 32'h0, 32'hDEADBEEF, 1);
    send(1, 5'd9, 0, 32'h99, 32'h99, 1);
    for (int i = 0; i < 5; i++) begin
      chk("ld_wait_hz_rs1", hz_rs1, 1);
      chk("ld_wait_hz_rs2", hz_rs2, 1);
      chk("ld_wait_no_wen", rf_wen, 0);
      cyc(1);
    end
    rsp(32'hDEADBEEF);
    chk("ld_hz_rs1_after_rsp", hz_rs1, 1);
    cyc(1);
    chk("ld_hz_rs1_x8_out", hz_rs1, 1);
    cyc(1);
    chk("ld_hz_rs1_x9_out", hz_rs1, 1);
    cyc(1);
    chk("ld_hz_rs1_cleared", hz_rs1, 0);
    chk("ld_retired_cnt", retired_cnt, 5);
    hz_rs1_addr = 5'd0;
    hz_rs2_addr = 5'd0;

    // Four pending loads fill the queue; a fifth result is held until space frees.
    send(1, 5'd10, 1, 32'h0, 32'hA, 1);
    send(1, 5'd11, 1, 32'h0, 32'hB, 1);
    send(1, 5'd12, 1, 32'h0, 32'hC, 1);
    send(1, 5'd13, 1, 32'h0, 32'hD, 1);
    chk("full_in_ready", in_ready, 0);
    fork
      send(1, 5'd14, 0, 32'hEE, 32'hEE, 1);
      begin
        for (int i = 0; i < 2; i++) begin
          cyc(1);
          chk("full_held", in_ready, 0);
        end
        rsp(32'hA);
        rsp(32'hB);
        rsp(32'hC);
        rsp(32'hD);
      end
    join
    cyc(8);
    chk("drain_in_ready", in_ready, 1);
    chk("drain_retired_cnt", retired_cnt, 10);

    // Orphan response into an empty queue sets the sticky flag, no write.
    chk("orphan_pre", err_orphan_rsp, 0);
    rsp(32'h77);
    chk("orphan_set", err_orphan_rsp, 1);
    cyc(3);
    chk("orphan_sticky", err_orphan_rsp, 1);

    // Write to x0: counted, never written, never a hazard.
    cnt0 = retired_cnt;
    hz_rs1_addr = 5'd0;
    send(1, 5'd0, 0, 32'h55, 32'h55, 1);
    chk("x0_hz_rs1", hz_rs1, 0);
    cyc(1);
    chk("x0_no_wen", rf_wen, 0);
    chk("x0_hz_rs1_out", hz_rs1, 0);
    chk("x0_retired_cnt", retired_cnt, cnt0 + 32'd1);

    // Reset mid-operation with two pending loads discards everything asynchronously.
    send(1, 5'd20, 0, 32'h2020, 32'h2020, 1);
    send(1, 5'd15, 1, 32'h0, 32'h0, 0);
    send(1, 5'd16, 1, 32'h0, 32'h0, 0);
    chk("pre_rst_waddr", rf_waddr, 20);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_wen", rf_wen, 0);
    chk("async_rst_waddr", rf_waddr, 0);
    chk("async_rst_wdata", rf_wdata, 0);
    chk("async_rst_cnt", retired_cnt, 0);
    chk("async_rst_err", err_orphan_rsp, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    rsp(32'h123);
    chk("post_rst_orphan", err_orphan_rsp, 1);
    cyc(4);
    chk("post_rst_cnt", retired_cnt, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
